// File: rtl/display_scan.sv
// display_scan: four-digit seven-segment scanner with per-frame digit snapshot.
// Optional leading-hour-zero blanking via SCAN_LZ_BLANK_EN.
module display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  output logic [1:0]  sel,
  output logic [3:0]  bcd,
  output logic        dp,
  output logic        blank,
  output logic        frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pcnt;
  logic [15:0]   shadow;
  logic [FW-1:0] fcnt;
  logic          blinkPhase;

  logic          tick;
  logic          wrap;
  logic          phaseNext;
  logic          lzNext;
  logic [1:0]    selNext;
  logic [15:0]   shadowNext;
  logic [3:0]    bcdNext;

  always_comb begin
    tick       = enable && (pcnt == P_LAST);
    selNext    = sel + 2'd1;
    wrap       = tick && (sel == 2'd3);
    // slot 0 of a new frame must already show the fresh snapshot
    shadowNext = wrap ? digits : shadow;
    phaseNext  = blinkPhase ^ (wrap && (fcnt == F_LAST));
    bcdNext    = shadowNext[{selNext, 2'b00} +: 4];
`ifdef SCAN_LZ_BLANK_EN
    lzNext     = (selNext == 2'd3) && (shadowNext[15:12] == 4'd0);
`else
    lzNext     = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt        <= '0;
      sel         <= 2'd0;
      shadow      <= 16'd0;
      fcnt        <= '0;
      blinkPhase  <= 1'b0;
      bcd         <= 4'd0;
      dp          <= 1'b0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else if (!enable) begin
      pcnt        <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        pcnt       <= '0;
        sel        <= selNext;
        shadow     <= shadowNext;
        blinkPhase <= phaseNext;
        bcd        <= bcdNext;
        dp         <= dp_mask[selNext];
        blank      <= (phaseNext && blink_mask[selNext]) || lzNext;
        if (wrap) begin
          fcnt <= (fcnt == F_LAST) ? '0 : fcnt + 1'b1;
        end
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: vector table plus scoreboard bench for display_scan.
// Runs with SCAN_DIV=4, BLINK_FRAMES=2.
`timescale 1ns/1ps
module tb_display_scan;

  localparam int SD = 4;
  localparam int BF = 2;
`ifdef SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpm;
    logic [3:0]  bm;
    logic [1:0]  s;
    logic [3:0]  b;
    logic        d;
    logic        bl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dpMask = 4'h0;
  logic [3:0]  blinkMask = 4'h0;
  logic [1:0]  sel;
  logic [3:0]  bcd;
  logic        dp;
  logic        blank;
  logic        frameStart;

  int   checks = 0;
  int   errors = 0;
  vec_t expQ[$];

  always #5 clk = ~clk;

  display_scan #(
    .SCAN_DIV(SD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .digits(digits),
    .dp_mask(dpMask),
    .blink_mask(blinkMask),
    .sel(sel),
    .bcd(bcd),
    .dp(dp),
    .blank(blank),
    .frame_start(frameStart)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] dig, input logic [3:0] dpm,
                              input logic [3:0] bm, input logic [1:0] s,
                              input logic [3:0] b, input logic d,
                              input logic bl);
    vec_t v;
    v.dig = dig; v.dpm = dpm; v.bm = bm;
    v.s = s; v.b = b; v.d = d; v.bl = bl;
    return v;
  endfunction

  // Scoreboard side: every sel change consumes one expected slot.
  logic [1:0] prevSel;
  int         monCnt = 0;
  always @(posedge clk) begin
    vec_t e;
    #1;
    if (!rst_n) begin
      monCnt  = 0;
      prevSel = sel;
    end else begin
      if (enable) monCnt++;
      else monCnt = 0;
      if (sel != prevSel) begin
        chk("fs_on_tick", {31'd0, frameStart}, {31'd0, sel == 2'd0});
        chk("slot_len", monCnt, SD);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: sel=%0d with empty queue", sel);
        end else begin
          e = expQ.pop_front();
          chk("sel", {30'd0, sel}, {30'd0, e.s});
          chk("bcd", {28'd0, bcd}, {28'd0, e.b});
          chk("dp", {31'd0, dp}, {31'd0, e.d});
          chk("blank", {31'd0, blank}, {31'd0, e.bl});
        end
        monCnt  = 0;
        prevSel = sel;
      end else begin
        chk("fs_idle", {31'd0, frameStart}, 32'd0);
      end
    end
  end

  task automatic waitChange(input string name);
    logic [1:0] s0;
    bit seen;
    s0 = sel;
    seen = 1'b0;
    for (int k = 0; k < 4 * SD + 4; k++) begin
      @(negedge clk);
      if (sel != s0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no sel change, got %0d required change", name, sel);
    end
  endtask

  initial begin
    vec_t vecs[27];
    int   lat;
    vecs[0]  = mk(16'h1234, 4'h0, 4'h0, 2'd1, 4'd0, 1'b0, 1'b0);
    vecs[1]  = mk(16'h1234, 4'h0, 4'h0, 2'd2, 4'd0, 1'b0, 1'b0);
    vecs[2]  = mk(16'h1234, 4'h0, 4'h0, 2'd3, 4'd0, 1'b0, LZ);
    vecs[3]  = mk(16'h1234, 4'h0, 4'h0, 2'd0, 4'd4, 1'b0, 1'b0);
    vecs[4]  = mk(16'h1234, 4'h0, 4'h0, 2'd1, 4'd3, 1'b0, 1'b0);
    vecs[5]  = mk(16'h5678, 4'h0, 4'h0, 2'd2, 4'd2, 1'b0, 1'b0);
    vecs[6]  = mk(16'h5678, 4'h0, 4'h0, 2'd3, 4'd1, 1'b0, 1'b0);
    vecs[7]  = mk(16'h5678, 4'h4, 4'h0, 2'd0, 4'd8, 1'b0, 1'b0);
    vecs[8]  = mk(16'h5678, 4'h4, 4'h0, 2'd1, 4'd7, 1'b0, 1'b0);
    vecs[9]  = mk(16'h5678, 4'h4, 4'h0, 2'd2, 4'd6, 1'b1, 1'b0);
    vecs[10] = mk(16'h5678, 4'h4, 4'h0, 2'd3, 4'd5, 1'b0, 1'b0);
    vecs[11] = mk(16'h0930, 4'h0, 4'h3, 2'd0, 4'd0, 1'b0, 1'b1);
    vecs[12] = mk(16'h0930, 4'h0, 4'h3, 2'd1, 4'd3, 1'b0, 1'b1);
    vecs[13] = mk(16'h0930, 4'h0, 4'h3, 2'd2, 4'd9, 1'b0, 1'b0);
    vecs[14] = mk(16'h0930, 4'h0, 4'h3, 2'd3, 4'd0, 1'b0, LZ);
    vecs[15] = mk(16'h0930, 4'h0, 4'h3, 2'd0, 4'd0, 1'b0, 1'b0);
    vecs[16] = mk(16'h0930, 4'h0, 4'h3, 2'd1, 4'd3, 1'b0, 1'b0);
    vecs[17] = mk(16'h0930, 4'h0, 4'h3, 2'd2, 4'd9, 1'b0, 1'b0);
    vecs[18] = mk(16'h0930, 4'h0, 4'h3, 2'd3, 4'd0, 1'b0, LZ);
    vecs[19] = mk(16'h0930, 4'h0, 4'h3, 2'd0, 4'd0, 1'b0, 1'b0);
    vecs[20] = mk(16'h0930, 4'h0, 4'h3, 2'd1, 4'd3, 1'b0, 1'b0);
    vecs[21] = mk(16'h0930, 4'h0, 4'h3, 2'd2, 4'd9, 1'b0, 1'b0);
    vecs[22] = mk(16'h0930, 4'h0, 4'h3, 2'd3, 4'd0, 1'b0, LZ);
    vecs[23] = mk(16'h0930, 4'h0, 4'h3, 2'd0, 4'd0, 1'b0, 1'b1);
    vecs[24] = mk(16'h0930, 4'h0, 4'h3, 2'd1, 4'd3, 1'b0, 1'b1);
    vecs[25] = mk(16'h0930, 4'h0, 4'h3, 2'd2, 4'd9, 1'b0, 1'b0);
    vecs[26] = mk(16'h0930, 4'h0, 4'h3, 2'd3, 4'd0, 1'b0, LZ);

    repeat (2) @(negedge clk);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_bcd", {28'd0, bcd}, 32'd0);
    chk("rst_dp", {31'd0, dp}, 32'd0);
    chk("rst_blank", {31'd0, blank}, 32'd1);
    chk("rst_fs", {31'd0, frameStart}, 32'd0);

    for (int i = 0; i < 27; i++) begin
      digits    = vecs[i].dig;
      dpMask    = vecs[i].dpm;
      blinkMask = vecs[i].bm;
      expQ.push_back(vecs[i]);
      if (i == 0) begin
        enable = 1'b1;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_tick_blank", {31'd0, blank}, 32'd1);
        chk("pre_tick_sel", {30'd0, sel}, 32'd0);
      end
      waitChange($sformatf("vec%0d", i));
    end

    // Enable drop: blank next edge, sel frozen.
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("dis_blank", {31'd0, blank}, 32'd1);
    chk("dis_sel", {30'd0, sel}, 32'd3);
    repeat (3) @(negedge clk);
    chk("dis_hold_sel", {30'd0, sel}, 32'd3);
    chk("dis_hold_blank", {31'd0, blank}, 32'd1);

    // Enable rise: first tick exactly SD edges later.
    blinkMask = 4'h0;
    expQ.push_back(mk(16'h0930, 4'h0, 4'h0, 2'd0, 4'd0, 1'b0, 1'b0));
    enable = 1'b1;
    lat = -1;
    for (int k = 1; k <= 2 * SD; k++) begin
      @(posedge clk);
      #1;
      if (k == SD - 1) chk("rise_blank_hold", {31'd0, blank}, 32'd1);
      if (sel != 2'd3) begin
        lat = k;
        break;
      end
    end
    chk("rise_latency", lat, SD);
    @(negedge clk);

    expQ.push_back(mk(16'h0930, 4'h0, 4'h0, 2'd1, 4'd3, 1'b0, 1'b0));
    waitChange("pre_reset_tick");

    // Asynchronous reset mid-slot.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", {30'd0, sel}, 32'd0);
    chk("arst_bcd", {28'd0, bcd}, 32'd0);
    chk("arst_dp", {31'd0, dp}, 32'd0);
    chk("arst_blank", {31'd0, blank}, 32'd1);
    chk("arst_fs", {31'd0, frameStart}, 32'd0);
    @(negedge clk);
    expQ.push_back(mk(16'h0930, 4'h0, 4'h0, 2'd1, 4'd0, 1'b0, 1'b0));
    rst_n = 1'b1;
    waitChange("post_reset_tick");

    @(negedge clk);
    chk("queue_drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
